// File: rtl/mu2cgra_stream_driver_if.sv
// Stream bus between the matrix-unit stand-in and the CGRA.
//   mu2cgra_valid : beat valid (master -> slave)
//   mu2cgra       : beat data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   cgra2mu_ready : slave accepts the current beat
// The master modport is used by the stream driver. The slave modport is
// for the consumer side, for example the CGRA or a testbench.
interface mu2cgra_stream_driver_if #(
    parameter int NUM_CH     = 32,
    parameter int DATA_WIDTH = 17
);
    logic                         mu2cgra_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] mu2cgra;
    logic                         cgra2mu_ready;

    modport master (
        output mu2cgra_valid,
        output mu2cgra,
        input  cgra2mu_ready
    );

    modport slave (
        input  mu2cgra_valid,
        input  mu2cgra,
        output cgra2mu_ready
    );
endinterface

// File: rtl/mu2cgra_stream_driver.sv
// Matrix-unit-to-CGRA stream source.
// Vectors are first pushed into an internal FIFO. They are then streamed to
// the CGRA under valid/ready for a programmed number of beats. There are
// four modes:
//   ZERO : every beat is all zeros
//   FIFO : the FIFO is drained in order
//   LOOP : the FIFO contents are replayed cyclically, without popping
//   RAMP : channel i of beat b = base + b*NUM_CH + i, wrapping
// Ports:
//   clk, reset_n                        clock, async active-low reset
//   cfg_mode/num_beats/ramp_base        run configuration, sampled on an accepted start
//   start                               1-cycle pulse, honoured only in IDLE
//   load_valid/load_data/load_ready     FIFO push port
//   stream (master)                     mu2cgra_valid / mu2cgra / cgra2mu_ready
//   busy, done                          running; 1-cycle completion pulse
//   underrun                            sticky: FIFO starved during a FIFO/LOOP run
//   fifo_count                          FIFO occupancy
module mu2cgra_stream_driver #(
    parameter int NUM_CH     = 32,
    parameter int DATA_WIDTH = 17,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [1:0]                    cfg_mode,
    input  logic [CNT_WIDTH-1:0]          cfg_num_beats,
    input  logic [DATA_WIDTH-1:0]         cfg_ramp_base,
    input  logic                          start,
    input  logic                          load_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]  load_data,
    output logic                          load_ready,
    mu2cgra_stream_driver_if.master       stream,
    output logic                          busy,
    output logic                          done,
    output logic                          underrun,
    output logic [$clog2(DEPTH+1)-1:0]    fifo_count
);
    localparam int VEC_W = NUM_CH * DATA_WIDTH;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] M_ZERO = 2'd0;
    localparam logic [1:0] M_FIFO = 2'd1;
    localparam logic [1:0] M_LOOP = 2'd2;
    localparam logic [1:0] M_RAMP = 2'd3;

    logic [VEC_W-1:0]      fifo_mem [DEPTH];
    logic [1:0]            state_reg;
    logic [1:0]            mode_reg;
    logic [CNT_WIDTH-1:0]  num_beats_reg;
    logic [CNT_WIDTH-1:0]  beat_cnt_reg;
    logic [DATA_WIDTH-1:0] ramp_base_reg;
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [CNT_W-1:0]      loop_len_reg;
    logic [CNT_W-1:0]      loop_idx_reg;
    logic                  underrun_reg;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  running;
    logic                  push;
    logic                  pop;
    logic                  xfer;
    logic                  last_beat;
    logic                  out_valid;
    logic [PTR_W-1:0]      rd_addr;
    logic [DATA_WIDTH-1:0] ramp_start;
    logic [VEC_W-1:0]      ramp_vec;
    logic [VEC_W-1:0]      out_data;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_W'(DEPTH));
    assign running    = (state_reg == S_RUN);

    // LOOP replays the stored entries, so pushes are blocked while it runs.
    assign load_ready = !fifo_full && !(running && mode_reg == M_LOOP);
    assign push       = load_valid && load_ready;
    assign xfer       = out_valid && stream.cgra2mu_ready;
    assign pop        = xfer && (mode_reg == M_FIFO);
    assign last_beat  = (beat_cnt_reg == num_beats_reg - CNT_WIDTH'(1));

    // LOOP reads at an offset from the (unmoving) read pointer.
    // loop_idx_reg < loop_len_reg <= DEPTH, so truncating it is safe.
    assign rd_addr = (mode_reg == M_LOOP) ? rd_ptr_reg + PTR_W'(loop_idx_reg) : rd_ptr_reg;

    // The ramp value wraps modulo 2^DATA_WIDTH. Only the low bits of
    // beat_cnt*NUM_CH matter.
    assign ramp_start = ramp_base_reg + DATA_WIDTH'(32'(beat_cnt_reg) * NUM_CH);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ramp
        assign ramp_vec[gi*DATA_WIDTH +: DATA_WIDTH] = ramp_start + DATA_WIDTH'(gi);
    end

    always_comb begin
        out_valid = 1'b0;
        if (running) begin
            case (mode_reg)
                M_FIFO:  out_valid = !fifo_empty;
                default: out_valid = 1'b1;
            endcase
        end
    end

    // Data depends only on registered state that moves on a handshake.
    // It is therefore stable while the beat is stalled.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            case (mode_reg)
                M_RAMP:         out_data = ramp_vec;
                M_FIFO, M_LOOP: out_data = fifo_mem[rd_addr];
                default:        out_data = '0;
            endcase
        end
    end

    assign stream.mu2cgra_valid = out_valid;
    assign stream.mu2cgra       = out_data;
    assign busy                 = running;
    assign done                 = (state_reg == S_DONE);
    assign underrun             = underrun_reg;
    assign fifo_count           = count_reg;

    // Storage has no reset. Stale contents are unreachable once the
    // pointers are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            mode_reg      <= M_ZERO;
            num_beats_reg <= '0;
            beat_cnt_reg  <= '0;
            ramp_base_reg <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            loop_len_reg  <= '0;
            loop_idx_reg  <= '0;
            underrun_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        mode_reg      <= cfg_mode;
                        num_beats_reg <= cfg_num_beats;
                        ramp_base_reg <= cfg_ramp_base;
                        beat_cnt_reg  <= '0;
                        loop_idx_reg  <= '0;
                        loop_len_reg  <= count_reg;
                        underrun_reg  <= (cfg_mode == M_LOOP) && fifo_empty;
                        // A zero-length run, or a FIFO/LOOP run with
                        // nothing stored, completes without streaming.
                        if (cfg_num_beats == '0 ||
                            ((cfg_mode == M_FIFO || cfg_mode == M_LOOP) && fifo_empty)) begin
                            state_reg <= S_DONE;
                        end else begin
                            state_reg <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (mode_reg == M_FIFO && fifo_empty) begin
                        underrun_reg <= 1'b1;
                    end
                    if (xfer) begin
                        beat_cnt_reg <= beat_cnt_reg + CNT_WIDTH'(1);
                        if (mode_reg == M_LOOP) begin
                            loop_idx_reg <= (loop_idx_reg == loop_len_reg - CNT_W'(1)) ?
                                            '0 : loop_idx_reg + CNT_W'(1);
                        end
                        if (last_beat) begin
                            state_reg <= S_DONE;
                        end
                    end
                end
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: tb/tb_mu2cgra_stream_driver.sv
module tb_mu2cgra_stream_driver;
    localparam int NUM_CH = 32;
    localparam int DW     = 17;
    localparam int DEPTH  = 16;
    localparam int CW     = 16;
    localparam int VW     = NUM_CH * DW;
    localparam int FCW    = $clog2(DEPTH + 1);

    localparam logic [1:0] M_ZERO = 2'd0;
    localparam logic [1:0] M_FIFO = 2'd1;
    localparam logic [1:0] M_LOOP = 2'd2;
    localparam logic [1:0] M_RAMP = 2'd3;

    typedef logic [VW-1:0] vec_t;

    typedef struct {
        logic [1:0]    mode;
        int            beats;
        logic [DW-1:0] base;
        logic [DW-1:0] exp_first_ch0;
        logic [DW-1:0] exp_first_ch2;
        logic [DW-1:0] exp_last_ch0;
    } vec_rec_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [1:0]     cfg_mode = '0;
    logic [CW-1:0]  cfg_num_beats = '0;
    logic [DW-1:0]  cfg_ramp_base = '0;
    logic           start = 1'b0;
    logic           load_valid = 1'b0;
    vec_t           load_data = '0;
    logic           load_ready;
    logic           busy;
    logic           done;
    logic           underrun;
    logic [FCW-1:0] fifo_count;

    mu2cgra_stream_driver_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) stream_if ();

    mu2cgra_stream_driver #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cfg_mode(cfg_mode),
        .cfg_num_beats(cfg_num_beats),
        .cfg_ramp_base(cfg_ramp_base),
        .start(start),
        .load_valid(load_valid),
        .load_data(load_data),
        .load_ready(load_ready),
        .stream(stream_if.master),
        .busy(busy),
        .done(done),
        .underrun(underrun),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cycle = 0;
    int   start_cyc = 0;
    int   valid_cycles = 0;
    int   ready_mode = 0;   // 0: always ready, 1: pattern 1,0,0 repeating, 2: never
    vec_t exp_q[$];
    vec_t model_fifo[$];
    vec_t got_q[$];
    int   got_cyc[$];
    logic held_pending = 1'b0;
    vec_t held_data = '0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_vec(input string name, input vec_t got, input vec_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t make_vec(input int k);
        vec_t v;
        for (int i = 0; i < NUM_CH; i++) v[i*DW +: DW] = DW'(100 * k + i);
        return v;
    endfunction

    function automatic vec_t ramp_model(input logic [DW-1:0] base, input int b);
        vec_t v;
        for (int i = 0; i < NUM_CH; i++) v[i*DW +: DW] = DW'(int'(base) + b * NUM_CH + i);
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < NUM_CH; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    // Ready generator
    initial begin
        int idx;
        idx = 0;
        stream_if.cgra2mu_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       stream_if.cgra2mu_ready = (idx % 3 == 0);
                2:       stream_if.cgra2mu_ready = 1'b0;
                default: stream_if.cgra2mu_ready = 1'b1;
            endcase
            idx++;
        end
    end

    // Monitor and scoreboard
    always @(negedge clk) begin
        if (!reset_n) begin
            held_pending = 1'b0;
        end else begin
            if (held_pending) begin
                chk("hold_valid", 64'(stream_if.mu2cgra_valid), 64'd1);
                chk_vec("hold_data", stream_if.mu2cgra, held_data);
            end
            if (!busy) begin
                chk("idle_valid", 64'(stream_if.mu2cgra_valid), 64'd0);
                chk_vec("idle_data", stream_if.mu2cgra, '0);
            end
            if (stream_if.mu2cgra_valid) valid_cycles++;
            if (stream_if.mu2cgra_valid && stream_if.cgra2mu_ready) begin
                got_q.push_back(stream_if.mu2cgra);
                got_cyc.push_back(cycle);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h expected none", stream_if.mu2cgra);
                end else begin
                    chk_vec("beat", stream_if.mu2cgra, exp_q.pop_front());
                end
            end
            held_pending = stream_if.mu2cgra_valid && !stream_if.cgra2mu_ready;
            held_data = stream_if.mu2cgra;
        end
    end

    task automatic load(input vec_t v);
        int t;
        t = 0;
        @(posedge clk);
        #1;
        load_valid = 1'b1;
        load_data = v;
        @(negedge clk);
        while (!load_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!load_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL load_timeout: got load_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        model_fifo.push_back(v);
    endtask

    // Push onto the scoreboard the beats that a run should produce.
    task automatic expect_run(input logic [1:0] mode, input int beats, input logic [DW-1:0] base);
        int n;
        case (mode)
            M_ZERO: for (int b = 0; b < beats; b++) exp_q.push_back('0);
            M_RAMP: for (int b = 0; b < beats; b++) exp_q.push_back(ramp_model(base, b));
            M_FIFO: begin
                n = (beats < model_fifo.size()) ? beats : model_fifo.size();
                for (int b = 0; b < n; b++) exp_q.push_back(model_fifo.pop_front());
            end
            default: begin
                if (model_fifo.size() > 0)
                    for (int b = 0; b < beats; b++) exp_q.push_back(model_fifo[b % model_fifo.size()]);
            end
        endcase
    endtask

    task automatic kick(input logic [1:0] mode, input int beats, input logic [DW-1:0] base);
        got_q.delete();
        got_cyc.delete();
        valid_cycles = 0;
        @(posedge clk);
        #1;
        cfg_mode = mode;
        cfg_num_beats = CW'(beats);
        cfg_ramp_base = base;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_cyc = cycle;
    endtask

    task automatic wait_done(output int lat, output int done_cnt, output logic busy_lr);
        lat = 0;
        done_cnt = 0;
        busy_lr = 1'b0;
        while (done_cnt == 0 && lat < 500) begin
            @(negedge clk);
            lat++;
            if (busy) busy_lr = busy_lr | load_ready;
            if (done) done_cnt++;
        end
        if (done_cnt == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done expected done within 500 cycles");
        end
        repeat (3) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
    endtask

    task automatic run(input logic [1:0] mode, input int beats, input logic [DW-1:0] base,
                       output int lat, output int done_cnt, output logic busy_lr);
        kick(mode, beats, base);
        wait_done(lat, done_cnt, busy_lr);
    endtask

    initial begin
        vec_rec_t tbl[5];
        int       lat;
        int       dcnt;
        logic     blr;
        vec_t     v;

        tbl[0] = '{M_RAMP, 2, 17'h1FFFE, 17'h1FFFE, 17'h00000, 17'h0001E};
        tbl[1] = '{M_RAMP, 3, 17'h00000, 17'h00000, 17'h00002, 17'h00040};
        tbl[2] = '{M_ZERO, 3, 17'h12345, 17'h00000, 17'h00000, 17'h00000};
        tbl[3] = '{M_RAMP, 1, 17'd100,   17'd100,   17'd102,   17'd100};
        tbl[4] = '{M_RAMP, 5, 17'h1FF00, 17'h1FF00, 17'h1FF02, 17'h1FF80};

        // 1: reset held with random inputs
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            start = 1'($urandom);
            load_valid = 1'($urandom);
            load_data = rand_vec();
            cfg_mode = 2'($urandom);
            cfg_num_beats = CW'($urandom_range(1, 20));
            @(negedge clk);
            chk("rst_valid", 64'(stream_if.mu2cgra_valid), 64'd0);
            chk_vec("rst_data", stream_if.mu2cgra, '0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_underrun", 64'(underrun), 64'd0);
            chk("rst_fifo_count", 64'(fifo_count), 64'd0);
            chk("rst_load_ready", 64'(load_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        load_valid = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_fifo_count", 64'(fifo_count), 64'd0);

        // 2: FIFO drain, always ready
        for (int k = 0; k < 4; k++) load(make_vec(k));
        @(negedge clk);
        chk("fifo_loaded_count", 64'(fifo_count), 64'd4);
        expect_run(M_FIFO, 4, '0);
        run(M_FIFO, 4, '0, lat, dcnt, blr);
        chk("fifo_beats", 64'(got_q.size()), 64'd4);
        if (got_q.size() == 4) begin
            chk("fifo_first_latency", 64'(got_cyc[0] - start_cyc), 64'd0);
            chk("fifo_consecutive", 64'(got_cyc[3] - got_cyc[0]), 64'd3);
        end
        chk("fifo_done_pulses", 64'(dcnt), 64'd1);
        chk("fifo_count_after", 64'(fifo_count), 64'd0);
        chk("fifo_underrun", 64'(underrun), 64'd0);
        chk("fifo_sb_empty", 64'(exp_q.size()), 64'd0);

        // 3: backpressure
        for (int k = 0; k < 4; k++) load(make_vec(10 + k));
        ready_mode = 1;
        expect_run(M_FIFO, 4, '0);
        run(M_FIFO, 4, '0, lat, dcnt, blr);
        ready_mode = 0;
        chk("bp_beats", 64'(got_q.size()), 64'd4);
        chk("bp_done_pulses", 64'(dcnt), 64'd1);
        chk("bp_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("bp_fifo_count", 64'(fifo_count), 64'd0);

        // 4: LOOP replay
        for (int k = 0; k < 3; k++) load(make_vec(20 + k));
        expect_run(M_LOOP, 7, '0);
        run(M_LOOP, 7, '0, lat, dcnt, blr);
        chk("loop_beats", 64'(got_q.size()), 64'd7);
        chk("loop_load_ready_in_run", 64'(blr), 64'd0);
        chk("loop_fifo_count", 64'(fifo_count), 64'd3);
        chk("loop_done_pulses", 64'(dcnt), 64'd1);
        chk("loop_sb_empty", 64'(exp_q.size()), 64'd0);
        // The contents are retained after LOOP: draining gives v0 v1 v2.
        expect_run(M_FIFO, 3, '0);
        run(M_FIFO, 3, '0, lat, dcnt, blr);
        chk("loop_retained_beats", 64'(got_q.size()), 64'd3);
        chk("loop_retained_sb", 64'(exp_q.size()), 64'd0);

        // 5: table-driven ZERO/RAMP runs
        for (int r = 0; r < 5; r++) begin
            expect_run(tbl[r].mode, tbl[r].beats, tbl[r].base);
            run(tbl[r].mode, tbl[r].beats, tbl[r].base, lat, dcnt, blr);
            chk($sformatf("tbl%0d_beats", r), 64'(got_q.size()), 64'(tbl[r].beats));
            if (got_q.size() > 0) begin
                v = got_q[0];
                chk($sformatf("tbl%0d_first_ch0", r), 64'(v[0 +: DW]), 64'(tbl[r].exp_first_ch0));
                chk($sformatf("tbl%0d_first_ch2", r), 64'(v[2*DW +: DW]), 64'(tbl[r].exp_first_ch2));
                v = got_q[got_q.size() - 1];
                chk($sformatf("tbl%0d_last_ch0", r), 64'(v[0 +: DW]), 64'(tbl[r].exp_last_ch0));
                chk($sformatf("tbl%0d_latency", r), 64'(got_cyc[0] - start_cyc), 64'd0);
            end
            chk($sformatf("tbl%0d_done_pulses", r), 64'(dcnt), 64'd1);
            chk($sformatf("tbl%0d_sb_empty", r), 64'(exp_q.size()), 64'd0);
        end

        // 6a: zero beats
        run(M_ZERO, 0, '0, lat, dcnt, blr);
        chk("zero_beats_latency", 64'(lat), 64'd1);
        chk("zero_beats_no_valid", 64'(valid_cycles), 64'd0);
        chk("zero_beats_done", 64'(dcnt), 64'd1);

        // 6b: FIFO start with an empty FIFO
        run(M_FIFO, 3, '0, lat, dcnt, blr);
        chk("fifo_empty_latency", 64'(lat), 64'd1);
        chk("fifo_empty_no_valid", 64'(valid_cycles), 64'd0);
        chk("fifo_empty_underrun", 64'(underrun), 64'd0);

        // 6c: LOOP start with an empty FIFO
        run(M_LOOP, 3, '0, lat, dcnt, blr);
        chk("loop_empty_latency", 64'(lat), 64'd1);
        chk("loop_empty_underrun", 64'(underrun), 64'd1);

        // 6d: underrun during a FIFO run, then resume
        load(make_vec(30));
        expect_run(M_FIFO, 1, '0);
        kick(M_FIFO, 2, '0);
        repeat (4) @(negedge clk);
        chk("ur_underrun", 64'(underrun), 64'd1);
        chk("ur_valid", 64'(stream_if.mu2cgra_valid), 64'd0);
        chk("ur_busy", 64'(busy), 64'd1);
        chk("ur_beats_so_far", 64'(got_q.size()), 64'd1);
        v = make_vec(31);
        exp_q.push_back(v);
        load(v);
        void'(model_fifo.pop_front());
        wait_done(lat, dcnt, blr);
        chk("ur_beats", 64'(got_q.size()), 64'd2);
        chk("ur_done_pulses", 64'(dcnt), 64'd1);
        chk("ur_sticky", 64'(underrun), 64'd1);
        chk("ur_fifo_count", 64'(fifo_count), 64'd0);
        expect_run(M_ZERO, 1, '0);
        run(M_ZERO, 1, '0, lat, dcnt, blr);
        chk("ur_cleared_on_start", 64'(underrun), 64'd0);

        // 6e: reset mid-run
        load(make_vec(40));
        load(make_vec(41));
        ready_mode = 2;
        @(posedge clk);
        expect_run(M_FIFO, 2, '0);
        kick(M_FIFO, 2, '0);
        repeat (3) @(negedge clk);
        chk("mr_busy_before", 64'(busy), 64'd1);
        chk("mr_valid_before", 64'(stream_if.mu2cgra_valid), 64'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_valid", 64'(stream_if.mu2cgra_valid), 64'd0);
        chk_vec("mr_data", stream_if.mu2cgra, '0);
        chk("mr_fifo_count", 64'(fifo_count), 64'd0);
        chk("mr_load_ready", 64'(load_ready), 64'd1);
        exp_q.delete();
        model_fifo.delete();
        dcnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("mr_no_done", 64'(dcnt), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ready_mode = 0;
        expect_run(M_RAMP, 2, 17'd5);
        run(M_RAMP, 2, 17'd5, lat, dcnt, blr);
        chk("mr_after_beats", 64'(got_q.size()), 64'd2);
        chk("mr_after_sb", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
